// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug-master and data-memory signals around the dmem arbiter.
// slave = arbiter side; master = the CPU/debug/memory environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Per-cycle arbiter sharing single-port data memory between the CPU load/store
// path and a debug master; debug wins contention until MAX_HOLD, then the CPU.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [3:0]        r_hold_cnt;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_dbg_own;
  logic              w_cpu_own;
  logic              w_dbg_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;

  always_comb begin
    w_dbg_own = bus.dbg_req & (~bus.cpu_req | (r_hold_cnt < HOLD_MAX));
    w_cpu_own = bus.cpu_req & ~w_dbg_own;
    w_dbg_rd  = w_dbg_own & ~bus.dbg_we;
    // With no owner the CPU side still drives address/data; only the strobe drops.
    w_addr    = w_dbg_own ? bus.dbg_addr  : bus.cpu_addr;
    w_wdata   = w_dbg_own ? bus.dbg_wdata : bus.cpu_wdata;
    w_we      = w_dbg_own ? bus.dbg_we    : (w_cpu_own & bus.cpu_we);
  end

  assign bus.mem_addr   = w_addr;
  assign bus.mem_wdata  = w_wdata;
  assign bus.mem_write  = w_we & ~rst;
  assign bus.dbg_gnt    = w_dbg_own & ~rst;
  assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_own & ~rst;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dbg_rvalid = r_dbg_rvalid;
  assign bus.dbg_rdata  = r_dbg_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt   <= '0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      // Counts consecutive debug wins over a waiting CPU.
      if (w_dbg_own & bus.cpu_req)
        r_hold_cnt <= (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 4'd1;
      else
        r_hold_cnt <= '0;
      r_dbg_rvalid <= w_dbg_rd;
      if (w_dbg_rd)
        r_dbg_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle arbitration,
// hand sequences for debug read latency, contention, stalled store, reset, withdraw.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for Data_memory: combinational read, write on rising edge.
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic e_stall, e_gnt, e_mw;
    logic [31:0] e_addr, e_wdata, e_crd;
  } vec_t;

  vec_t vt [7];

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
                              logic es, logic eg, logic em,
                              logic [31:0] eaddr, logic [31:0] ewd, logic [31:0] ecrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_stall = es; v.e_gnt = eg; v.e_mw = em;
    v.e_addr = eaddr; v.e_wdata = ewd; v.e_crd = ecrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    vt[0] = mk(1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0,     0,0,1, 32'h10,32'hDEADBEEF,32'h0);
    vt[1] = mk(1,0,32'h10,32'h0,        0,0,32'h0,32'h0,     0,0,0, 32'h10,32'h0,32'hDEADBEEF);
    vt[2] = mk(0,0,32'h44,32'h55,       0,0,32'h0,32'h0,     0,0,0, 32'h44,32'h55,32'h0);
    vt[3] = mk(0,0,32'h44,32'h0,        1,1,32'h30,32'hA5A5, 0,1,1, 32'h30,32'hA5A5,32'h0);
    vt[4] = mk(1,0,32'h30,32'h0,        0,0,32'h0,32'h0,     0,0,0, 32'h30,32'h0,32'hA5A5);
    vt[5] = mk(1,0,32'h10,32'h0,        1,1,32'h34,32'h77,   1,1,1, 32'h34,32'h77,32'h0);
    vt[6] = mk(0,0,32'h10,32'h0,        1,0,32'h10,32'h0,    0,1,0, 32'h10,32'h0,32'hDEADBEEF);

    // Reset state, with requests asserted to show the forced outputs.
    drive(1'b1, 1'b1, 32'h10, 32'h1234, 1'b1, 1'b1, 32'h14, 32'h5678);
    #1;
    chk("rst_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("rst_rdata",  bus.dbg_rdata, 32'h0);
    chk("rst_gnt",    32'(bus.dbg_gnt), 32'h0);
    chk("rst_stall",  32'(bus.cpu_stall), 32'h0);
    chk("rst_mw",     32'(bus.mem_write), 32'h0);
    chk("rst_hold",   32'(dut.r_hold_cnt), 32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); mem_clr = 1'b0; rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Single-cycle arbitration vectors (includes test 1: CPU store then 0-latency load).
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_gnt", i),   32'(bus.dbg_gnt),   32'(vt[i].e_gnt));
      chk($sformatf("v%0d_mw", i),    32'(bus.mem_write), 32'(vt[i].e_mw));
      chk($sformatf("v%0d_addr", i),  bus.mem_addr,  vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_crd", i),   bus.cpu_rdata, vt[i].e_crd);
    end

    // Debug read of 0x10: gnt in N, rvalid+data in N+1 only.
    idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("rd_gnt", 32'(bus.dbg_gnt), 32'h1);
    chk("rd_rvalid_N", 32'(bus.dbg_rvalid), 32'h0);
    idle(); #1;
    chk("rd_rvalid_N1", 32'(bus.dbg_rvalid), 32'h1);
    chk("rd_rdata_N1",  bus.dbg_rdata, 32'hDEADBEEF);
    idle(); #1;
    chk("rd_rvalid_N2", 32'(bus.dbg_rvalid), 32'h0);
    chk("rd_rdata_hold", bus.dbg_rdata, 32'hDEADBEEF);

    // Contention for 10 cycles: D,D,D,D,C repeating; hold 1,2,3,4,0.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
      #1;
      chk($sformatf("cont%0d_gnt", i),   32'(bus.dbg_gnt),   32'((i % 5) != 4));
      chk($sformatf("cont%0d_stall", i), 32'(bus.cpu_stall), 32'((i % 5) != 4));
      @(posedge clk); #1;
      chk($sformatf("cont%0d_hold", i), 32'(dut.r_hold_cnt), ((i % 5) == 4) ? 32'h0 : 32'(i % 5 + 1));
    end

    // Stalled CPU store vs debug write to the same word.
    idle();
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h20, 32'h1, 1'b1, 1'b1, 32'h20, 32'h2);
    #1;
    chk("st_gnt",   32'(bus.dbg_gnt), 32'h1);
    chk("st_stall", 32'(bus.cpu_stall), 32'h1);
    chk("st_wd0",   bus.mem_wdata, 32'h2);
    @(posedge clk); #1;
    chk("st_mem0", mem[8'h20], 32'h2);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h20, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("st_stall1", 32'(bus.cpu_stall), 32'h0);
    chk("st_mw1",    32'(bus.mem_write), 32'h1);
    chk("st_wd1",    bus.mem_wdata, 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("st_final", bus.cpu_rdata, 32'h1);

    // Async reset one cycle after a debug read grant.
    idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #2;
    chk("ar_pre_rvalid", 32'(bus.dbg_rvalid), 32'h1);
    chk("ar_pre_rdata",  bus.dbg_rdata, 32'h1);
    drive(1'b1, 1'b1, 32'h24, 32'h9, 1'b1, 1'b1, 32'h28, 32'h8);
    rst = 1'b1;
    #1;
    chk("ar_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("ar_rdata",  bus.dbg_rdata, 32'h0);
    chk("ar_gnt",    32'(bus.dbg_gnt), 32'h0);
    chk("ar_mw",     32'(bus.mem_write), 32'h0);
    @(posedge clk); #1;
    chk("ar_mem24", mem[8'h24], 32'h0);
    chk("ar_mem28", mem[8'h28], 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    // Withdraw: saturate hold, then debug pulses a write while the CPU wins.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'h99);
    #1;
    chk("wd_gnt",   32'(bus.dbg_gnt), 32'h0);
    chk("wd_stall", 32'(bus.cpu_stall), 32'h0);
    chk("wd_mw",    32'(bus.mem_write), 32'h0);
    chk("wd_addr",  bus.mem_addr, 32'h10);
    idle(); #1;
    chk("wd_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("wd_mem40",  mem[8'h40], 32'h0);
    chk("wd_hold",   32'(dut.r_hold_cnt), 32'h0);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
